// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the word-serial wide adder controller.
package wide_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Width of a counter that indexes n words; never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wide_add_ctrl_fan.sv
// Narrow ripple-carry adder slice reused word by word by wide_add_ctrl.
module fan #(
    parameter int N_BITS = 4
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic              cin,
    output logic [N_BITS-1:0] sum,
    output logic              cout
);

    // Carry kept in a procedural variable so the chain is one combinational walk.
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < N_BITS; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/wide_add_ctrl.sv
// Multi-precision add/subtract sequencer: walks wide operands LSB-first through
// one WORD_BITS adder slice, carrying between words in a register.
module wide_add_ctrl
    import wide_add_pkg::*;
#(
    parameter int WORD_BITS = 4,
    parameter int N_WORDS   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WORD_BITS*N_WORDS-1:0]   in_a,
    input  logic [WORD_BITS*N_WORDS-1:0]   in_b,
    input  logic                           in_cin,
    input  logic                           in_sub,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_BITS*N_WORDS-1:0]   out_sum,
    output logic                           out_cout,
    output logic                           out_ovf,
    output logic                           busy
);

    localparam int W  = WORD_BITS * N_WORDS;
    localparam int KB = idx_bits(N_WORDS);
    localparam logic [KB-1:0] K_LAST = KB'(N_WORDS - 1);

    state_t state_reg, state_next;

    logic [W-1:0]  a_reg, b_reg, sum_reg;
    logic          carry_reg, cout_reg, ovf_reg;
    logic [KB-1:0] k_reg;
    logic          in_ready_reg, out_valid_reg, busy_reg;

    logic [WORD_BITS-1:0] slice_a, slice_b, slice_sum;
    logic                 slice_cout;
    logic                 accept, last_word;

    assign accept    = in_ready_reg && in_valid;
    assign last_word = (k_reg == K_LAST);

    assign slice_a = a_reg[int'(k_reg) * WORD_BITS +: WORD_BITS];
    assign slice_b = b_reg[int'(k_reg) * WORD_BITS +: WORD_BITS];

    fan #(
        .N_BITS (WORD_BITS)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == IDLE);
            out_valid_reg <= (state_next == DONE);
            busy_reg      <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            k_reg     <= '0;
        end else begin
            if (accept) begin
                // Subtract is A + ~B + 1, so B is stored already inverted.
                a_reg     <= in_a;
                b_reg     <= in_sub ? ~in_b : in_b;
                carry_reg <= in_sub ? 1'b1 : in_cin;
                k_reg     <= '0;
            end
            if (state_reg == RUN) begin
                sum_reg[int'(k_reg) * WORD_BITS +: WORD_BITS] <= slice_sum;
                carry_reg <= slice_cout;
                k_reg     <= k_reg + KB'(1);
                if (last_word) begin
                    cout_reg <= slice_cout;
                    ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) &&
                                (slice_sum[WORD_BITS-1] != a_reg[W-1]);
                end
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: doc/wide_add_ctrl.md
# wide_add_ctrl

Multi-precision add/subtract sequencer that reuses one narrow ripple-carry adder slice to process wide operands one word per cycle. Operands arrive through a valid/ready handshake. The controller walks the words LSB-first and carries the slice carry-out between words in a register. It presents the full-width result, carry-out and signed overflow on a held valid/ready output. It sits between a wide-arithmetic requester (accumulator, address generator) and the area-cheap adder slice.

## Interface
- WORD_BITS, default 4: width of the adder slice and of one word.
- N_WORDS, default 4: words per operand; legal range 1..16. Total width W = WORD_BITS*N_WORDS.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in for add; ignored for subtract.
- in_sub  in  1  1 = A − B, 0 = A + B + cin.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_sum  out  W  result.
- out_cout  out  1  carry out of the MSB word. For subtract, 1 means no borrow.
- out_ovf  out  1  two's-complement overflow of the W-bit result.
- busy  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: one word per cycle.
  - DONE: out_valid=1.
- IDLE → RUN on acceptance. On that edge:
  - Latch A.
  - Latch B' = in_sub ? ~in_b : in_b.
  - Set carry = in_sub ? 1 : in_cin.
  - Set word index k = 0.
  - Latch the sub flag.
- RUN, per cycle:
  - The slice computes A[k] + B'[k] + carry.
  - sum word k is written from the slice output.
  - carry is updated from the slice carry-out.
  - k increments.
  - On the cycle with k = N_WORDS−1, go to DONE.
- DONE: out_sum, out_cout and out_ovf are held stable until out_valid && out_ready, then the state returns to IDLE.
- in_ready is 0 outside IDLE. in_valid asserted during RUN or DONE is ignored and must not corrupt the latched operands.
- Overflow is computed once the last word is done:
  - out_ovf = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]).
- Arithmetic is modulo 2^W. No saturation.
- Words that have not yet been written are not visible, because out_sum is only qualified by out_valid.
- An internal carry is never shared across operations: each acceptance reinitialises it.
- Reset at any state forces IDLE, clears every register and returns all outputs to their reset values. A half-finished operation is discarded with no output.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_sum = 0
  - out_cout = 0
  - out_ovf = 0
  - busy = 0
- Latency: if acceptance occurs at edge e0, out_valid rises after edge e0 + N_WORDS.
  - With N_WORDS = 1, out_valid is high in the cycle after acceptance.
- If out_ready is already high when out_valid rises, DONE lasts exactly one cycle. in_ready returns high the following cycle.
- Maximum throughput is one operation per N_WORDS + 2 cycles. No request may be accepted in the same cycle as the output handshake.
- All outputs come directly from registers. The only combinational path is through the slice inside RUN.

## Structure
- Package wide_add_pkg:
  - state_t enum {IDLE, RUN, DONE}.
  - function idx_bits(n) returning max(1, $clog2(n)) for sizing the word counter.
- One sub-module: a single instance of the team ripple-carry adder slice `fan` with N_BITS = WORD_BITS, fed by the word-k slices of A and B' and the carry register.
- Operand and sum storage are plain registers, indexed by k with part-selects.

## Test plan
Default parameters (W = 16) unless a scenario says otherwise.
- **Basic add:** 0x00FF + 0x0001, cin=0.
  - Result: sum 0x0100, cout 0, ovf 0.
  - out_valid exactly 4 cycles after acceptance.
- **Full carry ripple:** 0xFFFF + 0x0000, cin=1.
  - Result: sum 0x0000, cout 1, ovf 0.
- **Subtract with overflow:** 0x8000 − 0x0001, with in_cin=0 to prove it is ignored.
  - Result: sum 0x7FFF, cout 1, ovf 1.
- **Backpressure:** hold out_ready=0 for 5 cycles after out_valid rises, with in_valid held high carrying new operands.
  - Result stays stable; in_ready stays 0.
  - After out_ready rises, the new request is accepted and computed correctly.
- **Reset mid-RUN:** assert rst while k=2 of 0xFFFF + 0x0001.
  - All outputs are at reset values immediately.
  - After release, 0x0001 + 0x0001 gives 0x0002 with cout 0, proving no stale carry.
- **Single-word build:** WORD_BITS=4, N_WORDS=1, 0x7 + 0x1.
  - Result: sum 0x8, cout 0, ovf 1.
  - out_valid one cycle after acceptance.
